// File: rtl/set_cmd_dispatch.sv
// Command FIFO and job sequencer in front of the set-counter stage: queues
// commands, issues one job at a time, and returns one tagged result per job.
module set_cmd_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [23:0]              cmd_central,
  input  logic [11:0]              cmd_radius,
  input  logic [1:0]               cmd_mode,
  input  logic [3:0]               cmd_tag,
  output logic                     set_en,
  output logic [23:0]              set_central,
  output logic [11:0]              set_radius,
  output logic [1:0]               set_mode,
  input  logic                     set_busy,
  input  logic                     set_valid,
  input  logic [7:0]               set_candidate,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_tag,
  output logic [7:0]               res_count,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 24 + 12 + 2 + 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_tmo;
  logic [3:0]      r_tag;
  logic [23:0]     r_set_central;
  logic [11:0]     r_set_radius;
  logic [1:0]      r_set_mode;
  logic            r_res_valid;
  logic [3:0]      r_res_tag;
  logic [7:0]      r_res_count;
  logic            r_res_err;

  logic            w_cmd_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_tmo_hit;
  logic [EW-1:0]   w_head;

  // cmd_ready depends only on registered occupancy and rst, never on cmd_valid
  assign w_cmd_ready = (r_level < LW'(DEPTH)) && !rst;
  assign w_push      = cmd_valid && w_cmd_ready;
  assign w_head      = r_mem[r_rd_ptr];
  // r_tmo counts completed WAIT cycles; this is the cycle it would reach TIMEOUT
  assign w_tmo_hit   = (r_tmo == 8'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_level != '0) && !set_busy && !r_res_valid) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (set_valid || w_tmo_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_central, cmd_radius, cmd_mode, cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Job issue, wait/timeout and result holding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_set_central <= '0;
      r_set_radius  <= '0;
      r_set_mode    <= '0;
      r_tag         <= '0;
      r_tmo         <= '0;
      r_res_valid   <= 1'b0;
      r_res_tag     <= '0;
      r_res_count   <= '0;
      r_res_err     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_set_central <= w_head[41:18];
        r_set_radius  <= w_head[17:6];
        r_set_mode    <= w_head[5:4];
        r_tag         <= w_head[3:0];
      end
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 8'd1;
      end
      // set_valid takes priority over a coincident timeout
      if (r_state == S_WAIT) begin
        if (set_valid) begin
          r_res_count <= set_candidate;
          r_res_err   <= 1'b0;
        end else if (w_tmo_hit) begin
          r_res_count <= 8'hFF;
          r_res_err   <= 1'b1;
        end
      end
      if (r_state == S_RESP) begin
        r_res_valid <= 1'b1;
        r_res_tag   <= r_tag;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign set_en      = (r_state == S_ISSUE);
  assign set_central = r_set_central;
  assign set_radius  = r_set_radius;
  assign set_mode    = r_set_mode;
  assign res_valid   = r_res_valid;
  assign res_tag     = r_res_tag;
  assign res_count   = r_res_count;
  assign res_err     = r_res_err;
  assign fifo_level  = r_level;

endmodule
